// File: rtl/sram_req_queue_pkg.sv
// Shared definitions for the SRAM request queue: issuer states and default bus widths.
package sram_req_queue_pkg;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

endpackage

// File: rtl/sram_cmd_fifo.sv
// Synchronous command FIFO; pointers wrap modulo DEPTH (power of 2), level 0..DEPTH.
module sram_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 25
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign level   = count;
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_req_queue.sv
// Host-side front end for sram_controller: queues commands, issues them one at a
// time, returns one response per command, and times out a silent controller.
module sram_req_queue
  import sram_req_queue_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_rw,
  input  logic [ADDR_W-1:0]      cmd_addr,
  input  logic [DATA_W-1:0]      cmd_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_rw,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic                   ctrl_req,
  output logic                   ctrl_rw,
  output logic [ADDR_W-1:0]      ctrl_addr,
  output logic [DATA_W-1:0]      ctrl_wdata,
  output logic                   ctrl_burst_en,
  output logic [2:0]             ctrl_burst_len,
  input  logic [DATA_W-1:0]      ctrl_rdata,
  input  logic                   ctrl_ready,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int unsigned CMD_W = 1 + ADDR_W + DATA_W;
  localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_t           state_q;
  state_t           state_d;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  logic [CMD_W-1:0] fifo_din;
  logic [CMD_W-1:0] fifo_dout;
  logic [WD_W-1:0]  wd_q;
  logic             rsp_load;
  logic             rsp_err_d;

  assign fifo_push      = cmd_valid && !fifo_full;
  assign cmd_ready      = !fifo_full;
  assign fifo_din       = {cmd_rw, cmd_addr, cmd_wdata};
  assign ctrl_req       = (state_q == ST_ISSUE);
  assign rsp_valid      = (state_q == ST_RESP);
  assign ctrl_burst_en  = 1'b0;
  assign ctrl_burst_len = '0;

  sram_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .din     (fifo_din),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // ctrl_ready is checked before the watchdog so a done pulse in the last WAIT cycle wins.
  always_comb begin
    state_d   = state_q;
    fifo_pop  = 1'b0;
    rsp_load  = 1'b0;
    rsp_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (ctrl_ready) begin
          rsp_load = 1'b1;
          state_d  = ST_RESP;
        end else if (wd_q == WD_LAST) begin
          rsp_load  = 1'b1;
          rsp_err_d = 1'b1;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_rw    <= 1'b0;
      ctrl_addr  <= '0;
      ctrl_wdata <= '0;
      wd_q       <= '0;
      rsp_rw     <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      if (fifo_pop) {ctrl_rw, ctrl_addr, ctrl_wdata} <= fifo_dout;
      if (state_q == ST_WAIT) wd_q <= wd_q + WD_W'(1);
      else                    wd_q <= '0;
      if (rsp_load) begin
        rsp_rw    <= ctrl_rw;
        rsp_rdata <= (ctrl_ready && ctrl_rw) ? ctrl_rdata : '0;
        rsp_err   <= rsp_err_d;
      end
    end
  end

endmodule

// File: tb/tb_sram_req_queue.sv
// Scoreboard bench for sram_req_queue with a behavioural SRAM controller model.
module tb_sram_req_queue;

  localparam int unsigned TIMEOUT = 15;

  typedef struct {
    logic        rw;
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rw;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_rw;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        ctrl_req;
  logic        ctrl_rw;
  logic [7:0]  ctrl_addr;
  logic [15:0] ctrl_wdata;
  logic        ctrl_burst_en;
  logic [2:0]  ctrl_burst_len;
  logic [15:0] ctrl_rdata;
  logic        ctrl_ready;
  logic [2:0]  fifo_level;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   req_cnt = 0;
  int   last_req_cyc = 0;
  int   rsp_rise_cyc = 0;
  int   acc_cyc = 0;
  int   ready_delay = 2;
  bit   stub = 1'b0;
  logic prev_valid = 1'b0;
  logic prev_req = 1'b0;
  logic [15:0] sram [256];
  exp_t exp_q[$];

  sram_req_queue #(
    .DEPTH   (4),
    .ADDR_W  (8),
    .DATA_W  (16),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_rw         (cmd_rw),
    .cmd_addr       (cmd_addr),
    .cmd_wdata      (cmd_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rw         (rsp_rw),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .ctrl_req       (ctrl_req),
    .ctrl_rw        (ctrl_rw),
    .ctrl_addr      (ctrl_addr),
    .ctrl_wdata     (ctrl_wdata),
    .ctrl_burst_en  (ctrl_burst_en),
    .ctrl_burst_len (ctrl_burst_len),
    .ctrl_rdata     (ctrl_rdata),
    .ctrl_ready     (ctrl_ready),
    .fifo_level     (fifo_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drives one command (caller is just after a posedge); expected response queued on accept.
  task automatic send(input logic rw, input logic [7:0] a, input logic [15:0] d,
                      input logic [15:0] exp_rdata, input logic exp_err);
    exp_t e;
    int   n;
    cmd_valid = 1'b1;
    cmd_rw    = rw;
    cmd_addr  = a;
    cmd_wdata = d;
    n = 0;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      n++;
      if (n > 200) begin
        check("cmd_accept_timeout", 32'd1, 32'd0);
        cmd_valid = 1'b0;
        return;
      end
    end
    acc_cyc = cyc;
    e.rw = rw; e.rdata = exp_rdata; e.err = exp_err;
    exp_q.push_back(e);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0) begin
      @(posedge clk);
      n++;
      if (n > 300) begin
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Controller model: done pulse ready_delay cycles after the request; stub never answers.
  initial begin
    ctrl_ready = 1'b0;
    ctrl_rdata = 16'hDEAD;
    forever begin
      @(negedge clk);
      if (ctrl_req && reset_n) begin
        req_cnt++;
        last_req_cyc = cyc;
        if (!stub) begin
          repeat (ready_delay) @(posedge clk);
          #1;
          ctrl_ready = 1'b1;
          if (ctrl_rw) ctrl_rdata = sram[ctrl_addr];
          else         sram[ctrl_addr] = ctrl_wdata;
          @(posedge clk);
          #1;
          ctrl_ready = 1'b0;
          ctrl_rdata = 16'hDEAD;
        end
      end
    end
  end

  // Monitor: consumes the scoreboard on every accepted response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && rsp_valid && !prev_valid) rsp_rise_cyc = cyc;
      prev_valid = rsp_valid;
      if (reset_n && ctrl_req) check("req_single_cycle", {31'd0, prev_req}, 32'd0);
      prev_req = ctrl_req;
      if (reset_n && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_rw", {31'd0, rsp_rw}, {31'd0, e.rw});
          check("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, e.rdata});
          check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    int r0;
    int n;
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_rw    = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl_req", {31'd0, ctrl_req}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_fifo_level", {29'd0, fifo_level}, 32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_burst", {28'd0, ctrl_burst_en, ctrl_burst_len}, 32'd0);
    check("rst_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Write then read back through the controller model.
    send(1'b0, 8'h12, 16'hBEEF, 16'h0000, 1'b0);
    send(1'b1, 8'h12, 16'h0000, 16'hBEEF, 1'b0);
    wait_drain();

    // Latency from the accept cycle with an empty queue.
    send(1'b1, 8'h12, 16'h0000, 16'hBEEF, 1'b0);
    wait_drain();
    check("lat_ctrl_req", 32'(last_req_cyc - acc_cyc), 32'd2);
    check("lat_rsp_valid", 32'(rsp_rise_cyc - acc_cyc), 32'd5);

    // Done pulse in the final watchdog cycle still counts as success.
    ready_delay = TIMEOUT;
    send(1'b1, 8'h12, 16'h0000, 16'hBEEF, 1'b0);
    wait_drain();
    check("late_ready_lat", 32'(rsp_rise_cyc - last_req_cyc), 32'(TIMEOUT + 1));
    ready_delay = 2;

    // Silent controller: watchdog error with zero data.
    stub = 1'b1;
    send(1'b1, 8'h12, 16'h0000, 16'h0000, 1'b1);
    wait_drain();
    check("timeout_lat", 32'(rsp_rise_cyc - last_req_cyc), 32'(TIMEOUT + 1));
    stub = 1'b0;

    // Response held by host: outputs stable, nothing new issued.
    rsp_ready = 1'b0;
    r0 = req_cnt;
    send(1'b1, 8'h12, 16'h0000, 16'hBEEF, 1'b0);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    send(1'b0, 8'h30, 16'h5555, 16'h0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_rsp_data", {15'd0, rsp_rw, rsp_rdata}, {15'd0, 1'b1, 16'hBEEF});
      check("hold_ctrl_req", {31'd0, ctrl_req}, 32'd0);
    end
    check("hold_req_count", 32'(req_cnt - r0), 32'd1);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_drain();

    // Fill: DEPTH+1 commands with responses blocked; order preserved.
    rsp_ready = 1'b0;
    r0 = req_cnt;
    send(1'b0, 8'h20, 16'h1111, 16'h0000, 1'b0);
    send(1'b0, 8'h21, 16'h2222, 16'h0000, 1'b0);
    send(1'b1, 8'h20, 16'h0000, 16'h1111, 1'b0);
    send(1'b1, 8'h21, 16'h0000, 16'h2222, 1'b0);
    send(1'b0, 8'h20, 16'h3333, 16'h0000, 1'b0);
    cmd_valid = 1'b1;
    cmd_rw    = 1'b1;
    cmd_addr  = 8'h20;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_level", {29'd0, fifo_level}, 32'd4);
      check("full_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    check("full_req_count", 32'(req_cnt - r0), 32'd1);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    send(1'b1, 8'h20, 16'h0000, 16'h3333, 1'b0);
    wait_drain();

    // Reset while waiting on the controller with three commands queued.
    stub = 1'b1;
    for (int i = 0; i < 4; i++) send(1'b1, 8'(8'h40 + i), 16'h0000, 16'h0000, 1'b1);
    n = 0;
    while (!ctrl_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    exp_q.delete();
    check("arst_level", {29'd0, fifo_level}, 32'd0);
    check("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("arst_ctrl", {7'd0, ctrl_req, ctrl_rw, ctrl_addr, ctrl_wdata}, 32'd0);
    r0 = req_cnt;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("arst_no_req", 32'(req_cnt - r0), 32'd0);
    check("arst_level_after", {29'd0, fifo_level}, 32'd0);
    stub = 1'b0;

    // Operation resumes after reset; model SRAM contents persist.
    send(1'b1, 8'h21, 16'h0000, 16'h2222, 1'b0);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
